axi_lite_stream_master: RTL and testbench
=========================================

# axi_lite_stream_master

AXI4-Lite master (initiator) that turns an internal command stream into single AXI4-Lite read or write transactions, one outstanding at a time. Write data enters on a separate stream, read data leaves on an output stream, and write completion is signalled on a null stream. It is the initiator-side counterpart of the stream-to-AXI-slave top used for the compute functions. It lets a compute kernel drive a memory-mapped peripheral or test a slave top loop-back.

## Interface
Parameters:
- ADDR_N, 11, AXI byte-address width; also the width of the command word address.
- INT_N, 32, data width; fixed at 32 for AXI4-Lite; wstrb is 4 bits.

Ports:
- m_axi_aclk  in  1  sole clock.
- m_axi_aresetn  in  1  asynchronous, active-low reset.
- cmd  in  ADDR_N+1  {write flag (MSB), word address}; cmd_valid in 1; cmd_ready out 1.
- wd  in  INT_N  write data; wd_valid in 1; wd_ready out 1.
- rd  out  INT_N  read data; rd_valid out 1; rd_ready in 1.
- b_valid  out  1 / b_ready  in  1  write-done null stream.
- m_axi_awaddr out ADDR_N; m_axi_awvalid out; m_axi_awready in.
- m_axi_wdata out INT_N; m_axi_wstrb out 4; m_axi_wvalid out; m_axi_wready in.
- m_axi_bresp in 2; m_axi_bvalid in; m_axi_bready out.
- m_axi_araddr out ADDR_N; m_axi_arvalid out; m_axi_arready in.
- m_axi_rdata in INT_N; m_axi_rresp in 2; m_axi_rvalid in; m_axi_rready out.
- err_count  out  8  count of non-OKAY responses (see Configuration).

## Operation
- Handshakes: a transfer occurs on a rising edge with valid && ready. Valid, once asserted, holds with stable payload until the transfer.
- Byte address is {word address, 2'b00} truncated to ADDR_N bits; word-address bits above ADDR_N-2 are ignored.
- m_axi_wstrb is constant 4'b1111.
- FSM states: IDLE, W_FETCH, W_ADDR, W_RESP, B_OUT, R_ADDR, R_DATA, R_OUT.
- IDLE: cmd_ready=1. On a cmd transfer, latch the address and go to W_FETCH (write flag=1) or R_ADDR (write flag=0).
- W_FETCH: wd_ready=1. On a wd transfer, latch the data and go to W_ADDR.
- W_ADDR: awvalid and wvalid are both asserted on entry. Each deasserts independently after its own handshake; either may complete first or both in the same cycle. When both are done, go to W_RESP.
- W_RESP: bready=1. On bvalid, record bresp and go to B_OUT.
- B_OUT: b_valid=1 until b_ready, then go to IDLE.
- R_ADDR: arvalid=1 until arready, then go to R_DATA.
- R_DATA: rready=1. On rvalid, latch rdata and rresp, then go to R_OUT.
- R_OUT: rd_valid=1 with the latched data until rd_ready, then go to IDLE.
- Non-OKAY bresp/rresp does not alter the flow; data is still delivered and b_valid is still raised.

## Timing
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Reset values: all valid/ready outputs 0; cmd_ready 0 while reset is asserted, 1 in the first cycle after release; rd, addresses and wdata 0; err_count 0; state IDLE.
- Minimum latency with all partners ready:
  - Write: cmd accept at cycle 0 → wd accept at cycle 1 → aw/w handshake at cycle 2 → b handshake at cycle 3 → b_valid at cycle 4.
  - Read: cmd accept at cycle 0 → ar handshake at cycle 1 → r handshake at cycle 2 → rd_valid at cycle 3.
- Back-to-back: a new cmd is accepted no earlier than the cycle after the b_ready or rd_ready transfer.
- Reset mid-operation: state and outputs return to reset values asynchronously, and the in-flight AXI transaction is abandoned. The attached slave and interconnect must share the reset.
- wd is only consumed in W_FETCH; wd_valid asserted in any other state is ignored.

## Configuration
- AXI_MASTER_ERR_CNT_EN:
  - Defined: err_count increments by 1 on each bresp or rresp ≠ 2'b00 and saturates at 255. Reset clears it.
  - Undefined: err_count is tied to 0 and no counter logic is generated.

## Test plan
- Write cmd {1, 0x005}, wd=0xDEADBEEF, slave always ready → awaddr=0x014, wdata=0xDEADBEEF, wstrb=4'b1111; b_valid at cycle 4.
- Read cmd {0, 0x005}, slave returns 0x12345678 → araddr=0x014; rd=0x12345678 with rd_valid at cycle 3, held while rd_ready=0 for 5 cycles.
- Write where wready arrives 3 cycles after awready → awvalid drops after its handshake, wvalid holds until wready, and exactly one b handshake follows.
- Slave returns bresp=2'b10, then rresp=2'b11 → b_valid and rd are still delivered; err_count=2 with the macro defined, 0 without it.
- Reset asserted while in R_DATA → rready and all valids are 0 immediately; after release, a new read completes normally.
- Loop-back against the stream compute slave top: writing 0x00000007 to word 3 then reading word 3 returns 0x00000007.

Source files
------------

// File: rtl/axi_lite_stream_master.sv
// AXI4-Lite master: turns a command stream into single AXI4-Lite reads/writes, one outstanding at a time.
// Latency (all partners ready): write cmd->b_valid 4 cycles, read cmd->rd_valid 3 cycles.
// Backpressure: every stream/channel holds valid with stable payload until its ready; no input->output comb paths.
//
// Ports:
//   m_axi_aclk / m_axi_aresetn      clock, asynchronous active-low reset
//   cmd[ADDR_N:0] + valid/ready      {write flag, word address}
//   wd[INT_N-1:0] + valid/ready      write data, consumed only while fetching write data
//   rd[INT_N-1:0] + valid/ready      read data out
//   b_valid / b_ready                write-done null stream
//   m_axi_aw*/w*/b*/ar*/r*           AXI4-Lite master channels (wstrb fixed 4'b1111)
//   err_count[7:0]                   non-OKAY response counter
// Build option: define AXI_MASTER_ERR_CNT_EN to build the saturating error counter;
// otherwise err_count is tied to zero.

module axi_lite_stream_master #(
  parameter int ADDR_N = 11,
  parameter int INT_N  = 32
) (
  input  logic              m_axi_aclk,
  input  logic              m_axi_aresetn,
  input  logic [ADDR_N:0]   cmd,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [INT_N-1:0]  wd,
  input  logic              wd_valid,
  output logic              wd_ready,
  output logic [INT_N-1:0]  rd,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic              b_valid,
  input  logic              b_ready,
  output logic [ADDR_N-1:0] m_axi_awaddr,
  output logic              m_axi_awvalid,
  input  logic              m_axi_awready,
  output logic [INT_N-1:0]  m_axi_wdata,
  output logic [3:0]        m_axi_wstrb,
  output logic              m_axi_wvalid,
  input  logic              m_axi_wready,
  input  logic [1:0]        m_axi_bresp,
  input  logic              m_axi_bvalid,
  output logic              m_axi_bready,
  output logic [ADDR_N-1:0] m_axi_araddr,
  output logic              m_axi_arvalid,
  input  logic              m_axi_arready,
  input  logic [INT_N-1:0]  m_axi_rdata,
  input  logic [1:0]        m_axi_rresp,
  input  logic              m_axi_rvalid,
  output logic              m_axi_rready,
  output logic [7:0]        err_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_W_FETCH,
    S_W_ADDR,
    S_W_RESP,
    S_B_OUT,
    S_R_ADDR,
    S_R_DATA,
    S_R_OUT
  } state_t;

  state_t             r_state;
  logic               r_cmd_ready;
  logic               r_wd_ready;
  logic [INT_N-1:0]   r_rd;
  logic               r_rd_valid;
  logic               r_b_valid;
  logic [ADDR_N-1:0]  r_addr;
  logic [INT_N-1:0]   r_wdata;
  logic               r_awvalid;
  logic               r_wvalid;
  logic               r_bready;
  logic               r_arvalid;
  logic               r_rready;

  // The two top word-address bits fall off the byte address.
  logic w_unused_cmd;
  assign w_unused_cmd = &{1'b0, cmd[ADDR_N-1:ADDR_N-2]};

  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) begin
      r_state     <= S_IDLE;
      r_cmd_ready <= 1'b0;
      r_wd_ready  <= 1'b0;
      r_rd        <= '0;
      r_rd_valid  <= 1'b0;
      r_b_valid   <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_awvalid   <= 1'b0;
      r_wvalid    <= 1'b0;
      r_bready    <= 1'b0;
      r_arvalid   <= 1'b0;
      r_rready    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // cmd_ready comes up one edge after reset release, then stays up in IDLE.
          r_cmd_ready <= 1'b1;
          if (r_cmd_ready && cmd_valid) begin
            r_cmd_ready <= 1'b0;
            r_addr      <= {cmd[ADDR_N-3:0], 2'b00};
            if (cmd[ADDR_N]) begin
              r_wd_ready <= 1'b1;
              r_state    <= S_W_FETCH;
            end else begin
              r_arvalid <= 1'b1;
              r_state   <= S_R_ADDR;
            end
          end
        end
        S_W_FETCH: begin
          if (wd_valid) begin
            r_wdata    <= wd;
            r_wd_ready <= 1'b0;
            r_awvalid  <= 1'b1;
            r_wvalid   <= 1'b1;
            r_state    <= S_W_ADDR;
          end
        end
        S_W_ADDR: begin
          // AW and W retire independently; leave once neither is still pending.
          if (m_axi_awready) r_awvalid <= 1'b0;
          if (m_axi_wready)  r_wvalid  <= 1'b0;
          if ((!r_awvalid || m_axi_awready) && (!r_wvalid || m_axi_wready)) begin
            r_bready <= 1'b1;
            r_state  <= S_W_RESP;
          end
        end
        S_W_RESP: begin
          if (m_axi_bvalid) begin
            r_bready  <= 1'b0;
            r_b_valid <= 1'b1;
            r_state   <= S_B_OUT;
          end
        end
        S_B_OUT: begin
          if (b_ready) begin
            r_b_valid   <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        S_R_ADDR: begin
          if (m_axi_arready) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= S_R_DATA;
          end
        end
        S_R_DATA: begin
          if (m_axi_rvalid) begin
            r_rready   <= 1'b0;
            r_rd       <= m_axi_rdata;
            r_rd_valid <= 1'b1;
            r_state    <= S_R_OUT;
          end
        end
        S_R_OUT: begin
          if (rd_ready) begin
            r_rd_valid  <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef AXI_MASTER_ERR_CNT_EN
  logic [7:0] r_err_count;
  logic       w_err_evt;

  assign w_err_evt = (r_bready && m_axi_bvalid && (m_axi_bresp != 2'b00)) ||
                     (r_rready && m_axi_rvalid && (m_axi_rresp != 2'b00));

  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) begin
      r_err_count <= 8'd0;
    end else if (w_err_evt && (r_err_count != 8'hFF)) begin
      r_err_count <= r_err_count + 8'd1;
    end
  end

  assign err_count = r_err_count;
`else
  logic w_unused_resp;
  assign w_unused_resp = &{1'b0, m_axi_bresp, m_axi_rresp};
  assign err_count     = 8'd0;
`endif

  assign cmd_ready     = r_cmd_ready;
  assign wd_ready      = r_wd_ready;
  assign rd            = r_rd;
  assign rd_valid      = r_rd_valid;
  assign b_valid       = r_b_valid;
  assign m_axi_awaddr  = r_addr;
  assign m_axi_awvalid = r_awvalid;
  assign m_axi_wdata   = r_wdata;
  assign m_axi_wstrb   = 4'b1111;
  assign m_axi_wvalid  = r_wvalid;
  assign m_axi_bready  = r_bready;
  assign m_axi_araddr  = r_addr;
  assign m_axi_arvalid = r_arvalid;
  assign m_axi_rready  = r_rready;

endmodule

// File: tb/tb_axi_lite_stream_master.sv
// Testbench for axi_lite_stream_master: directed cases plus randomized traffic against a word-array model.
// Latency: n/a (bench).
// Backpressure: bench slave uses random ready/valid with tunable duty; stream side stalls b_ready/rd_ready.

module tb_axi_lite_stream_master;

  localparam int ADDR_N = 11;
  localparam int INT_N  = 32;

  logic              clk;
  logic              rst_n;
  logic [ADDR_N:0]   cmd;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [INT_N-1:0]  wd;
  logic              wd_valid;
  logic              wd_ready;
  logic [INT_N-1:0]  rd;
  logic              rd_valid;
  logic              rd_ready;
  logic              b_valid;
  logic              b_ready;
  logic [ADDR_N-1:0] m_axi_awaddr;
  logic              m_axi_awvalid;
  logic              m_axi_awready;
  logic [INT_N-1:0]  m_axi_wdata;
  logic [3:0]        m_axi_wstrb;
  logic              m_axi_wvalid;
  logic              m_axi_wready;
  logic [1:0]        m_axi_bresp;
  logic              m_axi_bvalid;
  logic              m_axi_bready;
  logic [ADDR_N-1:0] m_axi_araddr;
  logic              m_axi_arvalid;
  logic              m_axi_arready;
  logic [INT_N-1:0]  m_axi_rdata;
  logic [1:0]        m_axi_rresp;
  logic              m_axi_rvalid;
  logic              m_axi_rready;
  logic [7:0]        err_count;

  axi_lite_stream_master #(.ADDR_N(ADDR_N), .INT_N(INT_N)) dut (
    .m_axi_aclk    (clk),
    .m_axi_aresetn (rst_n),
    .cmd           (cmd),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .wd            (wd),
    .wd_valid      (wd_valid),
    .wd_ready      (wd_ready),
    .rd            (rd),
    .rd_valid      (rd_valid),
    .rd_ready      (rd_ready),
    .b_valid       (b_valid),
    .b_ready       (b_ready),
    .m_axi_awaddr  (m_axi_awaddr),
    .m_axi_awvalid (m_axi_awvalid),
    .m_axi_awready (m_axi_awready),
    .m_axi_wdata   (m_axi_wdata),
    .m_axi_wstrb   (m_axi_wstrb),
    .m_axi_wvalid  (m_axi_wvalid),
    .m_axi_wready  (m_axi_wready),
    .m_axi_bresp   (m_axi_bresp),
    .m_axi_bvalid  (m_axi_bvalid),
    .m_axi_bready  (m_axi_bready),
    .m_axi_araddr  (m_axi_araddr),
    .m_axi_arvalid (m_axi_arvalid),
    .m_axi_arready (m_axi_arready),
    .m_axi_rdata   (m_axi_rdata),
    .m_axi_rresp   (m_axi_rresp),
    .m_axi_rvalid  (m_axi_rvalid),
    .m_axi_rready  (m_axi_rready),
    .err_count     (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge counter: after posedge k (+#1) cyc == k.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: peripheral contents as a plain word array.
  logic [31:0] refm [0:511];
  int          n_wr = 0;
  int          n_rd = 0;

  // Slave knobs (written by the main sequence, read by the slave).
  int         pct      = 100;
  int         w_lag    = 0;
  bit         r_hold   = 1'b0;
  bit         err_rand = 1'b0;
  logic [1:0] force_b  = 2'b00;
  logic [1:0] force_r  = 2'b00;

  // Slave observations.
  logic [31:0] smem [0:511];
  logic [10:0] s_awaddr, s_araddr;
  logic [31:0] s_wdata;
  logic [3:0]  s_wstrb;
  int s_aw_n = 0, s_w_n = 0, s_b_n = 0, s_r_n = 0, n_wd_hs = 0, inj = 0;
  int s_aw_cyc = 0, s_w_cyc = 0;

  function automatic bit rnd(input int p);
    return int'($urandom_range(0, 99)) < p;
  endfunction

  // AXI4-Lite slave: detect transfers at negedge, drive new values just after posedge.
  initial begin : slave
    bit hs_aw, hs_w, hs_b, hs_ar, hs_r, aw_done, w_done, b_pend, r_pend;
    int w_age;
    aw_done = 0; w_done = 0; b_pend = 0; r_pend = 0; w_age = 0;
    m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00;
    m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_rresp = 2'b00; m_axi_rdata = '0;
    forever begin
      @(negedge clk);
      hs_aw = m_axi_awvalid && m_axi_awready;
      hs_w  = m_axi_wvalid && m_axi_wready;
      hs_b  = m_axi_bvalid && m_axi_bready;
      hs_ar = m_axi_arvalid && m_axi_arready;
      hs_r  = m_axi_rvalid && m_axi_rready;
      if (hs_aw) begin s_awaddr = m_axi_awaddr; s_aw_n++; s_aw_cyc = cyc + 1; end
      if (hs_w)  begin s_wdata = m_axi_wdata; s_wstrb = m_axi_wstrb; s_w_n++; s_w_cyc = cyc + 1; end
      if (hs_b)  begin s_b_n++; if (m_axi_bresp != 2'b00) inj++; end
      if (hs_ar) s_araddr = m_axi_araddr;
      if (hs_r)  begin s_r_n++; if (m_axi_rresp != 2'b00) inj++; end
      if (wd_valid && wd_ready) n_wd_hs++;
      @(posedge clk);
      #1;
      if (!rst_n) begin
        aw_done = 0; w_done = 0; b_pend = 0; r_pend = 0; w_age = 0; inj = 0;
        m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bvalid = 1'b0;
        m_axi_arready = 1'b0; m_axi_rvalid = 1'b0;
      end else begin
        if (hs_aw) aw_done = 1;
        if (hs_w)  w_done = 1;
        if (aw_done && w_done) begin
          smem[s_awaddr[10:2]] = s_wdata;
          aw_done = 0; w_done = 0; b_pend = 1;
        end
        if (hs_b) begin
          m_axi_bvalid = 1'b0; b_pend = 0;
        end else if (b_pend && !m_axi_bvalid && rnd(pct)) begin
          m_axi_bvalid = 1'b1;
          m_axi_bresp  = err_rand ? 2'($urandom_range(0, 3)) : force_b;
        end
        if (hs_ar) r_pend = 1;
        if (hs_r) begin
          m_axi_rvalid = 1'b0; r_pend = 0;
        end else if (r_pend && !m_axi_rvalid && !r_hold && rnd(pct)) begin
          m_axi_rvalid = 1'b1;
          m_axi_rdata  = smem[s_araddr[10:2]];
          m_axi_rresp  = err_rand ? 2'($urandom_range(0, 3)) : force_r;
        end
        m_axi_awready = rnd(pct);
        m_axi_arready = rnd(pct);
        if (m_axi_wvalid) w_age++; else w_age = 0;
        m_axi_wready = (w_age > w_lag) && rnd(pct);
      end
    end
  end

  function automatic bit sig(input int which);
    case (which)
      0: return cmd_ready;
      1: return wd_ready;
      2: return b_valid;
      3: return rd_valid;
      default: return 1'b0;
    endcase
  endfunction

  // Wait (bounded) for a DUT valid/ready; returns just after the edge at which it was seen.
  task automatic wait_hi(input int which, input string tag, output int hcyc, output bit ok,
                         output logic [31:0] snap);
    ok = 1'b0;
    snap = '0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (sig(which)) begin ok = 1'b1; snap = rd; break; end
    end
    chk(tag, 32'(ok), 32'd1);
    @(posedge clk);
    #1;
    hcyc = cyc;
  endtask

  task automatic send_cmd(input bit wr, input logic [10:0] waddr, output int acc);
    bit ok;
    logic [31:0] snap;
    cmd = {wr, waddr};
    cmd_valid = 1'b1;
    wait_hi(0, "cmd_ready", acc, ok, snap);
    cmd_valid = 1'b0;
    cmd = 12'($urandom);
  endtask

  task automatic do_write(input logic [10:0] waddr, input logic [31:0] data, input int bstall,
                          output int acc, output int bcyc);
    bit ok;
    int t;
    logic [31:0] snap;
    send_cmd(1'b1, waddr, acc);
    wd = data;
    wd_valid = 1'b1;
    wait_hi(1, "wd_ready", t, ok, snap);
    wd_valid = 1'b0;
    wd = $urandom;
    if (bstall > 0) begin
      wait_hi(2, "b_valid_stall", bcyc, ok, snap);
      repeat (bstall - 1) @(posedge clk);
      #1;
    end
    b_ready = 1'b1;
    wait_hi(2, "b_valid", bcyc, ok, snap);
    b_ready = 1'b0;
    refm[waddr[8:0]] = data;
    n_wr++;
    chk("awaddr", 32'(s_awaddr), 32'({waddr[8:0], 2'b00}));
    chk("wdata", s_wdata, data);
    chk("wstrb", 32'(s_wstrb), 32'hF);
  endtask

  task automatic do_read(input logic [10:0] waddr, input int rstall, output int acc,
                         output int vcyc, output logic [31:0] got);
    bit ok;
    int t;
    logic [31:0] exp;
    exp = refm[waddr[8:0]];
    wd = $urandom;
    wd_valid = 1'b1;  // must be ignored outside write-data fetch
    send_cmd(1'b0, waddr, acc);
    rd_ready = (rstall == 0);
    wait_hi(3, "rd_valid", vcyc, ok, got);
    if (rstall > 0) begin
      for (int i = 0; i < rstall; i++) begin
        @(negedge clk);
        chk("rd_hold_valid", 32'(rd_valid), 32'd1);
        chk("rd_hold_data", rd, exp);
      end
      @(posedge clk);
      #1;
      rd_ready = 1'b1;
      wait_hi(3, "rd_xfer", t, ok, got);
    end
    rd_ready = 1'b0;
    wd_valid = 1'b0;
    n_rd++;
    chk("araddr", 32'(s_araddr), 32'({waddr[8:0], 2'b00}));
    chk("rd_data", got, exp);
  endtask

  function automatic logic [31:0] out_flags();
    return 32'({cmd_ready, wd_ready, rd_valid, b_valid, m_axi_awvalid, m_axi_wvalid,
                m_axi_bready, m_axi_arvalid, m_axi_rready});
  endfunction

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int acc, bc, vc, a0, w0, b0, exp_err;
    bit ok;
    logic [31:0] got;
    for (int i = 0; i < 512; i++) begin
      smem[i] = 32'hA500_0000 | 32'(i);
      refm[i] = 32'hA500_0000 | 32'(i);
    end
    smem[5] = 32'h1234_5678;
    refm[5] = 32'h1234_5678;
    rst_n = 1'b0; cmd = '0; cmd_valid = 1'b0; wd = '0; wd_valid = 1'b0;
    rd_ready = 1'b0; b_ready = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_flags", out_flags(), 32'd0);
    chk("rst_rd", rd, 32'd0);
    chk("rst_awaddr", 32'(m_axi_awaddr), 32'd0);
    chk("rst_araddr", 32'(m_axi_araddr), 32'd0);
    chk("rst_wdata", m_axi_wdata, 32'd0);
    chk("rst_err", 32'(err_count), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("cmd_ready_after_rst", 32'(cmd_ready), 32'd1);

    // Read word 5 at full speed, with rd held for 5 stalled cycles
    do_read(11'h005, 5, acc, vc, got);
    chk("rd_latency", 32'(vc - acc), 32'd3);
    chk("rd_0x12345678", got, 32'h1234_5678);
    chk("araddr_0x014", 32'(s_araddr), 32'h014);

    // Write word 5 at full speed
    do_write(11'h005, 32'hDEAD_BEEF, 0, acc, bc);
    chk("wr_latency", 32'(bc - acc), 32'd4);
    chk("awaddr_0x014", 32'(s_awaddr), 32'h014);
    chk("wdata_deadbeef", s_wdata, 32'hDEAD_BEEF);

    // Back-to-back read at full speed straight after the b transfer
    do_read(11'h005, 0, acc, vc, got);
    chk("b2b_accept_gap", 32'(acc - bc), 32'd1);
    chk("b2b_rd_latency", 32'(vc - acc), 32'd3);

    // wready arrives 3 cycles after awready
    w_lag = 3;
    a0 = s_aw_n; w0 = s_w_n; b0 = s_b_n;
    do_write(11'h020, 32'hCAFE_F00D, 0, acc, bc);
    w_lag = 0;
    chk("lag_w_after_aw", 32'(s_w_cyc - s_aw_cyc), 32'd3);
    chk("lag_aw_once", 32'(s_aw_n - a0), 32'd1);
    chk("lag_w_once", 32'(s_w_n - w0), 32'd1);
    chk("lag_b_once", 32'(s_b_n - b0), 32'd1);

    // Error responses still deliver
    force_b = 2'b10;
    do_write(11'h030, 32'h0BAD_0001, 0, acc, bc);
    force_b = 2'b00;
    force_r = 2'b11;
    do_read(11'h030, 0, acc, vc, got);
    force_r = 2'b00;
`ifdef AXI_MASTER_ERR_CNT_EN
    exp_err = 2;
`else
    exp_err = 0;
`endif
    chk("err_count_after_errs", 32'(err_count), 32'(exp_err));

    // Loop-back: write 7 to word 3, read it back
    do_write(11'h003, 32'h0000_0007, 0, acc, bc);
    do_read(11'h003, 0, acc, vc, got);
    chk("loopback_word3", got, 32'h0000_0007);

    // Reset while waiting for read data
    r_hold = 1'b1;
    send_cmd(1'b0, 11'h044, acc);
    ok = 1'b0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (m_axi_rready) begin ok = 1'b1; break; end
    end
    chk("reached_rdata_wait", 32'(ok), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_flags", out_flags(), 32'd0);
    chk("rst_mid_err", 32'(err_count), 32'd0);
    r_hold = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    do_read(11'h044, 0, acc, vc, got);
    chk("post_rst_read", got, refm[9'h044]);

    // Randomized traffic
    err_rand = 1'b1;
    for (int k = 0; k < 60; k++) begin
      logic [10:0] wa;
      pct = int'($urandom_range(30, 100));
      wa = 11'($urandom);
      if ($urandom_range(0, 1) == 1)
        do_write(wa, $urandom, int'($urandom_range(0, 3)), acc, bc);
      else
        do_read(wa, int'($urandom_range(0, 3)), acc, vc, got);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    err_rand = 1'b0;
    pct = 100;
    repeat (3) @(posedge clk);
    @(negedge clk);

`ifdef AXI_MASTER_ERR_CNT_EN
    exp_err = (inj > 255) ? 255 : inj;
`else
    exp_err = 0;
`endif
    chk("err_count_final", 32'(err_count), 32'(exp_err));
    chk("aw_hs_total", 32'(s_aw_n), 32'(n_wr));
    chk("w_hs_total", 32'(s_w_n), 32'(n_wr));
    chk("b_hs_total", 32'(s_b_n), 32'(n_wr));
    chk("r_hs_total", 32'(s_r_n), 32'(n_rd));
    chk("wd_hs_total", 32'(n_wd_hs), 32'(n_wr));
    chk("idle_flags", out_flags(), 32'h100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
